// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response and fetch-to-decode handshake bundle.
interface fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   if_valid;
  logic                   if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [5:0]             if_opcode;
  logic [PC_WIDTH-1:0]    if_pc;
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect squash and valid/ready hand-off to decode.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 4
) (
  input  logic clk,
  input  logic rst_n,
  fetch_if.master f
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;
  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic                   valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   fire;
  logic                   pending;
  assign f.imem_req  = state == FETCH && (!valid || f.if_ready);
  assign f.imem_addr = pc;
  assign f.if_valid  = valid;
  assign f.if_instr  = instr;
  assign f.if_opcode = instr[INSTR_WIDTH-1 -: 6];
  assign f.if_pc     = instr_pc;
  assign fire        = f.imem_req && f.imem_gnt;
  // a response is still owed after this cycle only if one was granted and has not returned yet
  assign pending     = fire || ((state == WAIT || state == DRAIN) && !f.imem_rvalid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (f.redirect) begin
      pc    <= f.redirect_pc;
      valid <= 1'b0;
      instr <= '0;
      state <= pending ? DRAIN : FETCH;
    end else begin
      if (valid && f.if_ready) valid <= 1'b0;
      if (state == IDLE) state <= FETCH;
      else if (state == FETCH && fire) state <= WAIT;
      else if ((state == WAIT || state == DRAIN) && f.imem_rvalid) begin
        state <= FETCH;
        if (state == WAIT) begin
          instr    <= f.imem_rdata;
          instr_pc <= pc;
          valid    <= 1'b1;
          pc       <= pc + PC_WIDTH'(PC_STEP);
        end
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the opcode decoder (control unit). It holds the program counter, issues single-outstanding requests to instruction memory, registers each returned 32-bit word together with its 6-bit opcode and PC, and hands it to decode over a valid/ready handshake. It accepts taken-branch/jump redirects and discards wrong-path fetches.

## Interface
Parameters:
- PC_WIDTH, 32, program-counter and memory-address width
- INSTR_WIDTH, 32, instruction word width; opcode is bits [INSTR_WIDTH-1 : INSTR_WIDTH-6]
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, sequential PC increment

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address
- imem_gnt  in  1  memory accepts request this cycle (valid only while imem_req=1)
- imem_rvalid  in  1  read data valid, at least 1 cycle after grant
- imem_rdata  in  INSTR_WIDTH  read data
- redirect  in  1  taken branch/jump from execute (pc_src qualified by condition)
- redirect_pc  in  PC_WIDTH  redirect target
- if_valid  out  1  if_instr/if_opcode/if_pc hold a valid instruction
- if_ready  in  1  decode consumes the instruction this cycle
- if_instr  out  INSTR_WIDTH  registered instruction word
- if_opcode  out  6  if_instr[INSTR_WIDTH-1 -: 6], to control unit opcode input
- if_pc  out  PC_WIDTH  address of if_instr

## Operation
- States: IDLE, FETCH, WAIT, DRAIN. Internal pc register.
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_opcode=6'b000000 (NOP), if_pc=0.
- IDLE: unconditionally to FETCH next cycle.
- FETCH: imem_addr=pc; imem_req=1 when (!if_valid || if_ready). On imem_gnt -> WAIT.
- Once imem_req=1, imem_req and imem_addr stay stable until imem_gnt, except on redirect.
- WAIT: imem_req=0. On imem_rvalid: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP, -> FETCH. Slot is always free here (request only issued when slot empty or draining).
- Handshake: transfer when if_valid & if_ready; if_valid clears next cycle unless reloaded that cycle. Outputs held stable while if_valid & !if_ready.
- Redirect (highest priority, any state): pc<=redirect_pc; if_valid<=0, if_instr<=0 (decode sees NOP).
  - FETCH without gnt -> FETCH (new address next cycle).
  - FETCH with gnt same cycle -> DRAIN (old request in flight).
  - WAIT without rvalid -> DRAIN; WAIT with rvalid -> response discarded, -> FETCH.
  - DRAIN -> DRAIN (pc updated again, last redirect wins).
- DRAIN: imem_req=0; on imem_rvalid discard data, -> FETCH. No redirect-path data ever reaches if_*.
- PC arithmetic modulo 2^PC_WIDTH; pc+PC_STEP wraps from max to 0 silently.
- if_opcode is combinationally sliced from registered if_instr (no extra latency).

## Timing
- Reset release at edge 0: FETCH at cycle 1, imem_req=1 with imem_addr=RESET_PC at cycle 1.
- Grant at cycle n, rvalid at n+k (k>=1): if_valid=1 at n+k+1; next imem_req at n+k+1 (if slot free/consumed).
- Peak throughput with k=1, gnt immediate, if_ready=1: one instruction per 2 cycles.
- Redirect at cycle n: imem_addr=redirect_pc no earlier than n+1; if_valid=0 at n+1.
- Redirect and if_valid&if_ready same cycle: transfer completes (decode owns it), slot still cleared.
- Redirect has priority over simultaneous rvalid and gnt.

## Test plan
- Reset then memory returning addr-derived words (gnt immediate, k=1), if_ready=1 -> if_pc sequence 0,4,8,12; if_opcode equals rdata[31:26]; if_valid every other cycle.
- Backpressure: if_ready=0 for 5 cycles with instruction 0x24000005 held -> if_instr/if_pc stable, imem_req=0 throughout; first fetch re-issued the cycle if_ready=1.
- Redirect in WAIT to 0x100, rvalid 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never on if_instr; next imem_addr=0x100; next if_pc=0x100.
- Redirect same cycle as rvalid (and separately same cycle as gnt) -> data discarded, correct path fetched from redirect_pc, exactly one outstanding request.
- Wrap: RESET_PC=0xFFFFFFFC -> if_pc 0xFFFFFFFC then 0x00000000.
- rst_n asserted mid-WAIT -> all outputs return to reset values immediately (async); refetch from RESET_PC after release; stale rvalid ignored.
